// File: rtl/fact_pkg.sv
// Shared types and default constants for the factorial request controller.
//   fact_state_e : FSM state encoding, also exported on the cs debug port
//   FACT_*       : default parameter values for the controller
package fact_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GO   = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } fact_state_e;

    localparam int FACT_NW    = 4;
    localparam int FACT_RW    = 32;
    localparam int FACT_MAX_N = 12;
    localparam int FACT_TMO   = 64;

endpackage

// File: rtl/fact_tmo_cnt.sv
// Accelerator wait counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to 0 (takes priority over en)
//   en         : count one cycle of waiting
//   expired    : counter has reached TMO-1
// The counter holds at TMO-1, so it never wraps within one wait.
module fact_tmo_cnt #(
    parameter int TMO = fact_pkg::FACT_TMO
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [CW-1:0] LAST = CW'(TMO - 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fact_req_ctrl.sv
// Request controller in front of a factorial accelerator.
//   req_valid/req_ready/req_n        : request channel (operand in)
//   acc_go/acc_n                     : start pulse and operand to accelerator
//   acc_done/acc_result              : accelerator completion
//   rsp_valid/rsp_ready/rsp_result   : response channel
//   rsp_err                          : operand above MAX_N, accelerator not started
//   rsp_tmo                          : accelerator did not answer within TMO cycles
//   busy, cs                         : activity flag and state debug
// All outputs are Moore: decoded from the state and registers only.
module fact_req_ctrl
    import fact_pkg::*;
#(
    parameter int NW    = FACT_NW,
    parameter int RW    = FACT_RW,
    parameter int MAX_N = FACT_MAX_N,
    parameter int TMO   = FACT_TMO
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [NW-1:0] req_n,
    output logic          acc_go,
    output logic [NW-1:0] acc_n,
    input  logic          acc_done,
    input  logic [RW-1:0] acc_result,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [RW-1:0] rsp_result,
    output logic          rsp_err,
    output logic          rsp_tmo,
    output logic          busy,
    output logic [1:0]    cs
);

    fact_state_e state, state_nx;
    logic [NW-1:0] n;
    logic          req_ok;
    logic          expired;

    // Operand legality; widened so MAX_N larger than the operand range is fine.
    assign req_ok = ({{(33-NW){1'b0}}, req_n} <= 33'(MAX_N));

    fact_tmo_cnt #(.TMO(TMO)) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == S_GO),                  // cleared as WAIT is entered
        .en     ((state == S_WAIT) && !acc_done),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (req_valid) state_nx = req_ok ? S_GO : S_RESP;
            S_GO:   state_nx = S_WAIT;
            // done has priority over expiry in the same cycle
            S_WAIT: if (acc_done || expired) state_nx = S_RESP;
            S_RESP: if (rsp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n          <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            rsp_tmo    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        n <= req_n;
                        if (!req_ok) begin
                            rsp_result <= '0;
                            rsp_err    <= 1'b1;
                            rsp_tmo    <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (acc_done) begin
                        rsp_result <= acc_result;
                        rsp_err    <= 1'b0;
                        rsp_tmo    <= 1'b0;
                    end else if (expired) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b0;
                        rsp_tmo    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state == S_IDLE);
    assign acc_go    = (state == S_GO);
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);
    assign acc_n     = n;
    assign cs        = state;

endmodule

// File: tb/tb_fact_req_ctrl.sv
module tb_fact_req_ctrl;

    localparam int NW  = 4;
    localparam int RW  = 32;
    localparam int MX  = 12;
    localparam int TMO = 16;

    typedef struct {
        logic [RW-1:0] result;
        logic          err;
        logic          tmo;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready;
    logic [NW-1:0] req_n;
    logic          acc_go;
    logic [NW-1:0] acc_n;
    logic          acc_done;
    logic [RW-1:0] acc_result;
    logic          rsp_valid, rsp_ready;
    logic [RW-1:0] rsp_result;
    logic          rsp_err, rsp_tmo, busy;
    logic [1:0]    cs;

    int   checks = 0;
    int   errors = 0;
    int   go_seen = 0;
    int   go_exp = 0;
    rsp_t sb[$];

    fact_req_ctrl #(.NW(NW), .RW(RW), .MAX_N(MX), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
        .acc_go(acc_go), .acc_n(acc_n),
        .acc_done(acc_done), .acc_result(acc_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .rsp_tmo(rsp_tmo), .busy(busy), .cs(cs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare each response handshake with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && acc_go) go_seen++;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_rsp", 1, 0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("sb_result", rsp_result, e.result);
                chk("sb_err", {31'd0, rsp_err}, {31'd0, e.err});
                chk("sb_tmo", {31'd0, rsp_tmo}, {31'd0, e.tmo});
            end
        end
    end

    // One transaction. dly: WAIT-cycle index at which acc_done fires
    // (negative = never). hold: cycles of response backpressure.
    task automatic do_req(input int n, input int dly, input logic [RW-1:0] res, input int hold);
        rsp_t e;
        bit   legal;
        int   k;
        legal = (n <= MX);
        if (!legal)        e = '{result: '0,  err: 1'b1, tmo: 1'b0};
        else if (dly >= 0) e = '{result: res, err: 1'b0, tmo: 1'b0};
        else               e = '{result: '0,  err: 1'b0, tmo: 1'b1};
        chk("req_ready_idle", {31'd0, req_ready}, 1);
        req_valid = 1'b1;
        req_n     = NW'(n);
        sb.push_back(e);
        step();
        req_valid = 1'b0;
        req_n     = '0;
        if (!legal) begin
            chk("illegal_no_go", {31'd0, acc_go}, 0);
            chk("illegal_rsp_lat", {31'd0, rsp_valid}, 1);
        end else begin
            go_exp++;
            chk("go_lat", {31'd0, acc_go}, 1);
            chk("go_acc_n", {28'd0, acc_n}, n);
            step();
            chk("go_one_cycle", {31'd0, acc_go}, 0);
            chk("wait_state", {30'd0, cs}, 2);
            if (dly >= 0) begin
                repeat (dly) step();
                chk("acc_n_hold", {28'd0, acc_n}, n);
                acc_done   = 1'b1;
                acc_result = res;
                step();
                acc_done   = 1'b0;
                acc_result = '0;
                chk("done_rsp_lat", {31'd0, rsp_valid}, 1);
            end else begin
                k = 0;
                while (!rsp_valid && k < 40) begin
                    step();
                    k++;
                end
                chk("tmo_cycles", k, TMO);
            end
        end
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            chk("bp_valid", {31'd0, rsp_valid}, 1);
            chk("bp_result", rsp_result, e.result);
            chk("bp_flags", {30'd0, rsp_err, rsp_tmo}, {30'd0, e.err, e.tmo});
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("back_idle", {30'd0, cs}, 0);
        chk("rsp_dropped", {31'd0, rsp_valid}, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_n = '0;
        acc_done = 1'b0; acc_result = '0;
        rsp_ready = 1'b0;
        #2;
        chk("rst_go", {31'd0, acc_go}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", {30'd0, cs}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_req_ready", {31'd0, req_ready}, 1);
        chk("rst_acc_n", {28'd0, acc_n}, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_flags", {30'd0, rsp_err, rsp_tmo}, 0);
        #3 rst_n = 1'b1;
        step();
        chk("go_after_rst", {31'd0, acc_go}, 0);

        // acc_done outside WAIT is ignored
        acc_done = 1'b1; acc_result = 32'd99;
        step(); step();
        acc_done = 1'b0; acc_result = '0;
        chk("stray_done_cs", {30'd0, cs}, 0);
        chk("stray_done_rsp", {31'd0, rsp_valid}, 0);

        do_req(5, 3, 32'd120, 0);       // normal, done 4 cycles after go
        do_req(13, 0, 32'd0, 0);        // illegal operand
        do_req(15, 0, 32'd0, 2);        // illegal, max operand value
        do_req(12, 0, 32'd479001600, 0);// boundary legal, immediate done
        do_req(7, -1, 32'd0, 0);        // timeout
        do_req(6, TMO - 1, 32'd720, 0); // done in the expiry cycle
        do_req(4, 1, 32'd24, 5);        // backpressure
        do_req(0, 0, 32'd1, 0);

        // reset in WAIT abandons the transaction
        req_valid = 1'b1; req_n = 4'd9;
        step();
        req_valid = 1'b0;
        go_exp++;
        step(); step();
        chk("pre_rst_wait", {30'd0, cs}, 2);
        rst_n = 1'b0;
        #1;
        chk("rst_async_cs", {30'd0, cs}, 0);
        chk("rst_async_rsp", {31'd0, rsp_valid}, 0);
        chk("rst_async_go", {31'd0, acc_go}, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        chk("post_rst_go", {31'd0, acc_go}, 0);
        chk("post_rst_rsp", {31'd0, rsp_valid}, 0);
        do_req(3, 2, 32'd6, 0);

        step();
        chk("sb_empty", sb.size(), 0);
        chk("go_count", go_seen, go_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fact_req_ctrl.md
FACT_REQ_CTRL -- requirements
Module: fact_req_ctrl

Interface
REQ-001 The block SHALL have parameter NW, default 4, the operand width.
REQ-002 The block SHALL have parameter RW, default 32, the result width.
REQ-003 The block SHALL have parameter MAX_N, default 12, the largest legal operand.
REQ-004 The block SHALL have parameter TMO, default 64, the accelerator wait limit in cycles (TMO ≥ 2).
REQ-005 Port clk, input, 1: the single clock; all state updates on posedge clk.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Ports req_valid (input, 1), req_ready (output, 1), req_n (input, NW): request channel.
REQ-008 Ports acc_go (output, 1), acc_n (output, NW): start pulse and operand to the factorial accelerator.
REQ-009 Ports acc_done (input, 1), acc_result (input, RW): accelerator completion and result.
REQ-010 Ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_result (output, RW): response channel.
REQ-011 Ports rsp_err (output, 1), rsp_tmo (output, 1): response status flags.
REQ-012 Ports busy (output, 1), cs (output, 2): activity flag and current-state debug port.

Function
REQ-013 The FSM SHALL have four states: IDLE=0, GO=1, WAIT=2, RESP=3. cs SHALL equal the state code.
REQ-014 All outputs SHALL be Moore, decoded from state and registers only.
- req_ready=1 only in IDLE.
- acc_go=1 only in GO.
- rsp_valid=1 only in RESP.
- busy=1 when not in IDLE.
REQ-015 IDLE: when req_valid=1, the block SHALL capture req_n into the n register.
- If req_n ≤ MAX_N: next state GO.
- Otherwise: next state RESP with rsp_err=1, rsp_tmo=0, rsp_result=0, and no acc_go pulse.
REQ-016 GO SHALL last exactly one cycle, then move to WAIT. The timeout counter SHALL be cleared to 0 on entry to WAIT.
REQ-017 acc_n SHALL equal the captured n from the GO cycle through the end of WAIT, and SHALL hold that value otherwise.
REQ-018 WAIT with acc_done=1: capture acc_result into rsp_result, set rsp_err=0 and rsp_tmo=0, next state RESP.
REQ-019 WAIT with acc_done=0: increment the counter. When the counter equals TMO-1, next state RESP with rsp_tmo=1, rsp_err=0, rsp_result=0.
REQ-020 If acc_done=1 in the same cycle the counter reaches TMO-1, done SHALL win: normal result, rsp_tmo=0.
REQ-021 acc_done asserted outside WAIT SHALL be ignored.
REQ-022 RESP: rsp_result, rsp_err and rsp_tmo SHALL stay stable while rsp_valid=1 and rsp_ready=0. When rsp_ready=1, next state IDLE.
REQ-023 Latency:
- Request handshake at cycle t gives acc_go at t+1.
- acc_done at cycle d gives rsp_valid at d+1.
- An illegal operand gives rsp_valid at t+1.
REQ-024 The block SHALL accept one request at a time; a new request SHALL NOT be accepted in the same cycle as a response handshake.
REQ-025 The timeout counter SHALL be ceil(log2(TMO)) bits wide and SHALL never wrap within one WAIT.

Reset
REQ-026 On rst_n=0, the block SHALL asynchronously reset to:
- state IDLE;
- n, rsp_result and the counter cleared to 0;
- rsp_err=0 and rsp_tmo=0.
REQ-027 Reset mid-operation in any state SHALL abandon the transaction without emitting a response. acc_go SHALL be 0 during reset and in the first cycle after release.

Structure
REQ-028 Package fact_pkg SHALL hold the state enum type, the state codes, and the default constants for NW, RW, MAX_N and TMO.
REQ-029 The timeout counter SHALL be a sub-module fact_tmo_cnt with inputs clr and en and output expired.

Verification
REQ-030 Normal: req_n=5, acc_done with acc_result=120 four cycles after acc_go -> single-cycle acc_go with acc_n=5; rsp_result=120, rsp_err=0, rsp_tmo=0.
REQ-031 Illegal operand: req_n=13 -> no acc_go; rsp_valid one cycle after the request; rsp_err=1, rsp_result=0.
REQ-032 Timeout: TMO=16, acc_done never asserted -> rsp_tmo=1 exactly 16 cycles after entering WAIT.
REQ-033 Tie: TMO=16, acc_done=1 with acc_result=720 in the expiry cycle -> rsp_result=720, rsp_tmo=0.
REQ-034 Backpressure: rsp_ready held low 5 cycles after a result of 24 -> rsp_valid and rsp_result=24 stable throughout; IDLE the cycle after rsp_ready=1.
REQ-035 Reset in WAIT: rst_n pulsed low -> cs=0 immediately, no rsp_valid; the next req_n=3 with acc_result=6 completes normally.
